// File: rtl/fetch_queue.sv
// fetch_queue: fetches aligned instruction pairs into a 16-bit FIFO.
// Define FETCHQ_BYPASS_EN to show an empty-queue response same cycle.
module fetch_queue #(
  parameter int DEPTH = 8,
  parameter int PC_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic                   imem_req,
  output logic [PC_W-1:0]        imem_addr,
  input  logic                   imem_gnt,
  input  logic                   imem_rvalid,
  input  logic [31:0]            imem_rdata,
  input  logic                   redirect_valid,
  input  logic [PC_W-1:0]        redirect_pc,
  input  logic                   isstall,
  input  logic                   issingleinstr,
  output logic [15:0]            instr1_o,
  output logic [15:0]            instr2_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT
  } state_t;

  state_t          r_state;
  state_t          w_state_nx;
  logic [15:0]     r_mem [DEPTH];
  logic [AW-1:0]   r_head;
  logic [AW-1:0]   r_tail;
  logic [CW-1:0]   r_count;
  logic [PC_W-1:0] r_pc;
  logic            r_skip;
  logic            r_drop;

  logic            w_rsp;
  logic            w_push;
  logic            w_byp;
  logic            w_space;
  logic [1:0]      w_nin;
  logic [1:0]      w_want;
  logic [1:0]      w_pop;
  logic [1:0]      w_qpop;
  logic [1:0]      w_wr_n;
  logic [15:0]     w_in0;
  logic [15:0]     w_in1;
  logic [15:0]     w_wr0;
  logic [CW-1:0]   w_avail;
  logic [CW:0]     w_after;
  logic [AW-1:0]   w_head1;
  logic [AW-1:0]   w_tail1;

  assign w_rsp  = (r_state == S_WAIT) && imem_rvalid && !r_drop;
  assign w_push = w_rsp && !redirect_valid;
  assign w_nin  = r_skip ? 2'd1 : 2'd2;
  assign w_in0  = r_skip ? imem_rdata[31:16] : imem_rdata[15:0];
  assign w_in1  = imem_rdata[31:16];

`ifdef FETCHQ_BYPASS_EN
  assign w_byp = w_push && (r_count == '0);
`else
  assign w_byp = 1'b0;
`endif

  assign w_want = isstall ? 2'd0 :
                  (issingleinstr ? 2'd1 : 2'd2);

  // During bypass the pop is taken from the incoming pair itself
  assign w_avail = w_byp ? CW'(w_nin) : r_count;
  assign w_pop   = (w_avail < CW'(w_want)) ?
                   w_avail[1:0] : w_want;
  assign w_qpop  = w_byp ? 2'd0 : w_pop;
  assign w_wr0   = (w_byp && w_pop != 2'd0) ? w_in1 : w_in0;

  always_comb begin
    w_wr_n = 2'd0;
    if (w_push) begin
      if (w_byp) w_wr_n = w_nin - w_pop;
      else       w_wr_n = w_nin;
    end
  end

  assign w_head1 = r_head + 1'b1;
  assign w_tail1 = r_tail + 1'b1;

  // Reserve room for a whole pair before asking for it
  assign w_after = {1'b0, r_count} - (CW+1)'(w_pop)
                 + (CW+1)'(2);
  assign w_space = w_after <= (CW+1)'(DEPTH);

  always_comb begin
    instr1_o = 16'h0;
    instr2_o = 16'h0;
    if (w_byp) begin
      instr1_o = w_in0;
      instr2_o = r_skip ? 16'h0 : w_in1;
    end else begin
      if (r_count >= CW'(1)) instr1_o = r_mem[r_head];
      if (r_count >= CW'(2)) instr2_o = r_mem[w_head1];
    end
  end

  assign count_o   = r_count;
  assign imem_addr = r_pc;

  always_comb begin
    w_state_nx = r_state;
    imem_req   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!redirect_valid && w_space)
          w_state_nx = S_REQ;
      end
      S_REQ: begin
        imem_req = !redirect_valid;
        if (redirect_valid)
          w_state_nx = S_IDLE;
        else if (imem_gnt)
          w_state_nx = S_WAIT;
      end
      S_WAIT: begin
        if (imem_rvalid)
          w_state_nx = S_IDLE;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_pc    <= '0;
      r_skip  <= 1'b0;
      r_drop  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      if (redirect_valid) begin
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
        r_pc    <= {redirect_pc[PC_W-1:1], 1'b0};
        r_skip  <= redirect_pc[0];
        r_drop  <= (r_state == S_WAIT) && !imem_rvalid;
      end else begin
        r_head  <= r_head + AW'(w_qpop);
        r_tail  <= r_tail + AW'(w_wr_n);
        r_count <= r_count - CW'(w_qpop) + CW'(w_wr_n);
        if (imem_req && imem_gnt)
          r_pc <= r_pc + PC_W'(2);
        if (w_push)
          r_skip <= 1'b0;
        if (r_state == S_WAIT && imem_rvalid)
          r_drop <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_n != 2'd0)
      r_mem[r_tail] <= w_wr0;
    if (w_wr_n == 2'd2)
      r_mem[w_tail1] <= w_in1;
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: randomized self-checking bench for fetch_queue,
// checked against a queue-level model and a simple memory responder.
`timescale 1ns/1ps
module tb_fetch_queue;

  localparam int DEPTH = 8;
  localparam int PC_W  = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        redirect_valid = 1'b0;
  logic [15:0] redirect_pc = '0;
  logic        isstall = 1'b0;
  logic        issingleinstr = 1'b0;
  logic [15:0] instr1_o;
  logic [15:0] instr2_o;
  logic [3:0]  count_o;

  fetch_queue #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .isstall(isstall),
    .issingleinstr(issingleinstr),
    .instr1_o(instr1_o),
    .instr2_o(instr2_o),
    .count_o(count_o)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] mq[$];
  logic [15:0] mpc = '0;
  bit          mskip = 0;
  bit          mdrop = 0;
  bit          m_pend = 0;
  bit          m_ign = 0;
  int          m_wait = 0;
  logic [15:0] m_addr = '0;
  logic [15:0] m_exp = '0;
  int          last_push = -1;

  int          gnt_pct = 100;
  int          lat_min = 1;
  int          lat_max = 1;
  bit          st_stall = 0;
  bit          st_single = 0;
  bit          st_redir = 0;
  logic [15:0] st_rpc = '0;

  function automatic logic [15:0] f(input logic [15:0] a);
    return 16'(16'h1234 + a * 16'h1111);
  endfunction

  task automatic cycle();
    logic [15:0] view[$];
    logic [15:0] inw[$];
    logic [15:0] e1;
    logic [15:0] e2;
    logic [3:0]  ec;
    logic [15:0] s_addr;
    bit          s_req;
    bit          s_gnt;
    bit          acc;
    bit          byp;
    int          want;
    int          pop;
    @(negedge clk);
    isstall        = st_stall;
    issingleinstr  = st_single;
    redirect_valid = st_redir;
    redirect_pc    = st_rpc;
    imem_gnt       = 1'b0;
    if (m_pend && m_wait == 0) begin
      imem_rvalid = 1'b1;
      imem_rdata  = {f(m_addr + 16'd1), f(m_addr)};
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
    #1;
    imem_gnt = imem_req &&
               (int'($urandom_range(99)) < gnt_pct);
    s_req  = imem_req;
    s_addr = imem_addr;
    s_gnt  = imem_gnt;
    acc = imem_rvalid && !m_ign && !mdrop && !st_redir;
    if (mskip) inw = '{f(m_exp + 16'd1)};
    else       inw = '{f(m_exp), f(m_exp + 16'd1)};
    view = mq;
    byp = 0;
`ifdef FETCHQ_BYPASS_EN
    byp = acc && (mq.size() == 0);
`endif
    if (byp) view = inw;
    e1 = (view.size() >= 1) ? view[0] : 16'h0;
    e2 = (view.size() >= 2) ? view[1] : 16'h0;
    ec = 4'(mq.size());
    n_tests++;
    if (instr1_o !== e1) begin
      n_fail++;
      $display("FAIL instr1: got %h expected %h", instr1_o, e1);
    end
    n_tests++;
    if (instr2_o !== e2) begin
      n_fail++;
      $display("FAIL instr2: got %h expected %h", instr2_o, e2);
    end
    n_tests++;
    if (count_o !== ec) begin
      n_fail++;
      $display("FAIL count: got %0d expected %0d", count_o, ec);
    end
    n_tests++;
    if (s_req && m_pend && !m_ign) begin
      n_fail++;
      $display("FAIL one_outstanding: got req=1 expected 0");
    end
    n_tests++;
    if (s_addr[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL addr_even: got %h expected even", s_addr);
    end
    @(posedge clk);
    if (s_gnt) begin
      n_tests++;
      if (s_addr !== mpc) begin
        n_fail++;
        $display("FAIL grant_addr: got %h expected %h",
                 s_addr, mpc);
      end
    end
    if (st_redir) begin
      mq.delete();
      if (imem_rvalid) mdrop = 0;
      else if (m_pend && !m_ign) mdrop = 1;
      mpc   = {st_rpc[15:1], 1'b0};
      mskip = st_rpc[0];
    end else begin
      if (imem_rvalid && !m_ign && mdrop) mdrop = 0;
      want = st_stall ? 0 : (st_single ? 1 : 2);
      if (byp) foreach (inw[i]) mq.push_back(inw[i]);
      pop = (want < mq.size()) ? want : mq.size();
      repeat (pop) void'(mq.pop_front());
      if (acc && !byp) foreach (inw[i]) mq.push_back(inw[i]);
      if (acc) begin
        mskip = 0;
        last_push = int'(m_exp);
      end
      n_tests++;
      if (mq.size() > DEPTH) begin
        n_fail++;
        $display("FAIL overflow: got %0d entries max %0d",
                 mq.size(), DEPTH);
      end
    end
    if (imem_rvalid) begin
      m_pend = 0;
      m_ign  = 0;
    end else if (m_pend && m_wait > 0) begin
      m_wait--;
    end
    if (s_gnt) begin
      m_pend = 1;
      m_addr = s_addr;
      m_exp  = mpc;
      mpc    = mpc + 16'd2;
      m_wait = int'($urandom_range(lat_max, lat_min)) - 1;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n          = 1'b0;
    imem_gnt       = 1'b0;
    imem_rvalid    = 1'b0;
    redirect_valid = 1'b0;
    isstall        = 1'b0;
    issingleinstr  = 1'b0;
    mq.delete();
    mpc   = '0;
    mskip = 0;
    mdrop = 0;
    if (m_pend) begin
      m_ign  = 1;
      m_wait = 0;
    end
    #1;
    n_tests++;
    if (imem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_req: got %b expected 0", imem_req);
    end
    n_tests++;
    if (imem_addr !== 16'h0) begin
      n_fail++;
      $display("FAIL rst_addr: got %h expected 0", imem_addr);
    end
    n_tests++;
    if (instr1_o !== 16'h0 || instr2_o !== 16'h0) begin
      n_fail++;
      $display("FAIL rst_instr: got %h %h expected 0 0",
               instr1_o, instr2_o);
    end
    n_tests++;
    if (count_o !== 4'd0) begin
      n_fail++;
      $display("FAIL rst_count: got %0d expected 0", count_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_cold_fetch();
    st_stall = 1;
    gnt_pct  = 100;
    lat_min  = 1;
    lat_max  = 1;
    test_reset();
    @(posedge clk);
    #1;
    n_tests++;
    if (imem_req !== 1'b1 || imem_addr !== 16'h0) begin
      n_fail++;
      $display("FAIL cold_req: got req=%b addr=%h expected 1 0000",
               imem_req, imem_addr);
    end
    cycle();
    cycle();
    #1;
    n_tests++;
    if (instr1_o !== 16'h1234 || instr2_o !== 16'h2345) begin
      n_fail++;
      $display("FAIL cold_data: got %h %h expected 1234 2345",
               instr1_o, instr2_o);
    end
    n_tests++;
    if (count_o !== 4'd2) begin
      n_fail++;
      $display("FAIL cold_count: got %0d expected 2", count_o);
    end
  endtask

  task automatic test_single_issue();
    logic [15:0] b;
    logic [15:0] c;
    int n;
    st_stall = 1;
    gnt_pct  = 100;
    lat_max  = 2;
    for (int i = 0; i < 60 && mq.size() < 4; i++) cycle();
    gnt_pct = 0;
    for (int i = 0; i < 10 && m_pend; i++) cycle();
    n_tests++;
    if (mq.size() < 4 || m_pend) begin
      n_fail++;
      $display("FAIL single_setup: got %0d entries expected >=4",
               mq.size());
    end else begin
      b = mq[1];
      c = mq[2];
      n = mq.size();
      st_stall  = 0;
      st_single = 1;
      cycle();
      st_single = 0;
      st_stall  = 1;
      #1;
      n_tests++;
      if (instr1_o !== b || instr2_o !== c) begin
        n_fail++;
        $display("FAIL single: got %h %h expected %h %h",
                 instr1_o, instr2_o, b, c);
      end
      n_tests++;
      if (count_o !== 4'(n - 1)) begin
        n_fail++;
        $display("FAIL single_count: got %0d expected %0d",
                 count_o, n - 1);
      end
    end
  endtask

  task automatic test_stall();
    logic [15:0] a;
    logic [15:0] b;
    int n;
    st_stall = 1;
    gnt_pct  = 0;
    a = mq[0];
    b = mq[1];
    n = mq.size();
    repeat (3) begin
      cycle();
      #1;
      n_tests++;
      if (instr1_o !== a || instr2_o !== b ||
          count_o !== 4'(n)) begin
        n_fail++;
        $display("FAIL stall: got %h %h %0d expected %h %h %0d",
                 instr1_o, instr2_o, count_o, a, b, n);
      end
    end
  endtask

  task automatic test_redirect_odd();
    st_stall = 1;
    gnt_pct  = 0;
    for (int i = 0; i < 10 && m_pend; i++) cycle();
    lat_min = 3;
    lat_max = 3;
    gnt_pct = 100;
    for (int i = 0; i < 20 && !m_pend; i++) cycle();
    n_tests++;
    if (!m_pend) begin
      n_fail++;
      $display("FAIL redir_setup: got no grant expected one");
    end
    st_redir = 1;
    st_rpc   = 16'h0041;
    cycle();
    st_redir  = 0;
    lat_min   = 1;
    lat_max   = 1;
    last_push = -1;
    for (int i = 0; i < 30 && last_push < 0; i++) cycle();
    n_tests++;
    if (last_push != 'h40) begin
      n_fail++;
      $display("FAIL redir_fetch: got %0h expected 40", last_push);
    end
    #1;
    n_tests++;
    if (count_o !== 4'd1 || instr2_o !== 16'h0) begin
      n_fail++;
      $display("FAIL redir_skip: got cnt=%0d i2=%h expected 1 0000",
               count_o, instr2_o);
    end
    n_tests++;
    if (instr1_o !== f(16'h0041)) begin
      n_fail++;
      $display("FAIL redir_hi: got %h expected %h",
               instr1_o, f(16'h0041));
    end
  endtask

  task automatic test_backpressure_full();
    st_stall = 1;
    st_redir = 1;
    st_rpc   = 16'h0100;
    cycle();
    st_redir = 0;
    gnt_pct  = 100;
    lat_min  = 1;
    lat_max  = 3;
    repeat (40) cycle();
    #1;
    n_tests++;
    if (count_o !== 4'(DEPTH) || imem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL full: got cnt=%0d req=%b expected %0d 0",
               count_o, imem_req, DEPTH);
    end
    gnt_pct   = 0;
    st_stall  = 0;
    st_single = 0;
    cycle();
    #1;
    n_tests++;
    if (count_o !== 4'(DEPTH - 2) || imem_req !== 1'b1) begin
      n_fail++;
      $display("FAIL drain: got cnt=%0d req=%b expected %0d 1",
               count_o, imem_req, DEPTH - 2);
    end
    gnt_pct = 100;
    for (int i = 0; i < 10 && !m_pend; i++) cycle();
    n_tests++;
    if (!m_pend) begin
      n_fail++;
      $display("FAIL resume: got no grant expected one");
    end
  endtask

  task automatic test_random();
    gnt_pct = 60;
    lat_min = 1;
    lat_max = 3;
    repeat (600) begin
      st_stall  = ($urandom_range(3) == 0);
      st_single = 1'($urandom_range(1));
      st_redir  = ($urandom_range(19) == 0);
      st_rpc    = 16'($urandom);
      cycle();
    end
    st_redir = 0;
  endtask

  task automatic test_reset_mid();
    st_stall  = 1;
    st_single = 0;
    gnt_pct   = 0;
    for (int i = 0; i < 10 && m_pend; i++) cycle();
    gnt_pct = 100;
    lat_min = 3;
    lat_max = 3;
    for (int i = 0; i < 20 && !m_pend; i++) cycle();
    test_reset();
    lat_min = 1;
    lat_max = 2;
    cycle();
    #1;
    n_tests++;
    if (count_o !== 4'd0) begin
      n_fail++;
      $display("FAIL stale_after_reset: got %0d expected 0",
               count_o);
    end
    repeat (20) cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_cold_fetch();
    test_single_issue();
    test_stall();
    test_redirect_odd();
    test_backpressure_full();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
